calc1_port_resp: RTL and testbench
==================================

Name: calc1_port_resp

Overview:
- Synthesizable responder for one calc1 request port: the calculator side of the two-cycle cmd/data request and one-cycle resp/data reply protocol driven by the calc1 benches.
- Accepts a command plus operand 1, then operand 2 on the next cycle.
- Computes the result and returns a single response pulse after a fixed latency.
- Serves as a golden port model and as the per-port engine for a future multi-port calculator.

Parameters:
- LATENCY, 3, cycles from the operand-2 cycle to the response cycle; legal range 1..15.

Ports:
- c_clk  input  1  clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_cmd_in  input  4  command: 0 no-op, 1 add, 2 subtract, 5 shift left, 6 shift right; all other codes invalid.
- req_data_in  input  32  operand bus, bit 0 = MSB; carries op1 in the command cycle and op2 in the following cycle.
- out_resp  output  2  0 none, 1 success, 2 overflow/underflow/invalid command, 3 internal error.
- out_data  output  32  result, bit 0 = MSB; meaningful only when out_resp = 1, otherwise 0.
- busy  output  1  high from the op2 cycle through the response cycle inclusive.

Behaviour:
- Reset:
  - out_resp = 0, out_data = 0, busy = 0, state IDLE, latency counter 0.
  - Reset asserted in any state aborts the transaction; no response is ever issued for it.
- States:
  - IDLE -> OP2 when req_cmd_in != 0: latch cmd and op1.
  - OP2 (one cycle): latch op2; req_cmd_in is ignored in this cycle; load counter = LATENCY-1; go to EXEC (if LATENCY = 1, go straight to RESP).
  - EXEC: decrement counter; at 0 go to RESP.
  - RESP (one cycle): drive out_resp/out_data, then return to IDLE.
- Timing:
  - Command at cycle N, op2 at cycle N+1, response visible after the edge of cycle N+1+LATENCY, held exactly one cycle.
  - Outputs are registered and return to 0 on the following cycle.
- Commands arriving in OP2, EXEC or RESP are ignored (not queued, no response).
  - A command presented in the same cycle that RESP is driven is dropped.
  - The earliest accepted follow-on command is the cycle after RESP.
- Arithmetic (32-bit unsigned):
  - Add: 33-bit sum; carry out -> resp 2, data 0; else resp 1, data = low 32 bits.
  - Subtract: op2 > op1 -> resp 2, data 0 (underflow); else resp 1, data = op1 - op2.
  - Shift left/right: logical; amount = low 5 bits of op2 (bits 27:31), upper bits of op2 ignored; never errors; shift by 0 returns op1.
  - Invalid cmd (3, 4, 7..15): still consumes the op2 cycle and the full latency, then resp 2, data 0.
  - resp 3 is never generated by this block; it is reserved.
- Boundaries:
  - 0xFFFF_FFFF + 0 -> resp 1.
  - 0xFFFF_FFFF + 1 -> resp 2.
  - 5 - 5 -> resp 1, data 0.
  - 0 + 0 -> resp 1, data 0; the response cycle is distinguished from idle by resp = 1.

Optional Feature:
- CALC1_SHIFT_EN defined: cmd 5/6 perform shifts as above.
- Undefined: shifter not instantiated; cmd 5/6 are treated as invalid (resp 2, data 0, same timing).

Decomposition:
- Package calc1_pkg:
  - Command codes: CMD_NOP = 0, CMD_ADD = 1, CMD_SUB = 2, CMD_SHL = 5, CMD_SHR = 6.
  - Response codes: RESP_NONE = 0, RESP_OK = 1, RESP_ERR = 2, RESP_INTERR = 3.
  - FSM state enum.
  - Data width constant 32.
- One combinational sub-module, calc1_alu: cmd, op1, op2 -> result, resp code. The FSM/latency shell stays in calc1_port_resp.

Test Plan:
- reset 4 cycles; cmd 1 op1 0x0000_0001 then op2 0x01FF_FFFF -> resp 1, data 0x0200_0000 exactly LATENCY+1 cycles after cmd cycle, one cycle wide.
- cmd 1 op1 0xFFFF_FFFF op2 0x0000_0001 -> resp 2, data 0; then cmd 2 op1 1 op2 0xF -> resp 2, data 0; cmd 2 op1 0xF op2 1 -> resp 1, data 0xE.
- cmd 3 and cmd 4 each with op2 1 -> resp 2, data 0, same latency as add; busy high for LATENCY+1 cycles.
- With CALC1_SHIFT_EN: cmd 5 op1 0x0000_0001 op2 0xFFFF_FFE4 -> resp 1, data 0x0000_0010; cmd 6 op1 0x8000_0000 op2 31 -> data 1. Without the macro: both -> resp 2.
- Second cmd 1 issued during EXEC -> ignored, exactly one response; cmd issued the cycle after RESP -> accepted normally.
- reset pulsed one cycle during EXEC -> no response ever appears, outputs 0, next cmd 1 0+0 -> resp 1, data 0.

Source files
------------

// File: rtl/calc1_pkg.sv
// rtl/calc1_pkg.sv - shared command/response codes, FSM states and widths for calc1
package calc1_pkg;

    localparam int DATA_W = 32;

    localparam logic [3:0] CMD_NOP = 4'd0;
    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_SHL = 4'd5;
    localparam logic [3:0] CMD_SHR = 4'd6;

    localparam logic [1:0] RESP_NONE   = 2'd0;
    localparam logic [1:0] RESP_OK     = 2'd1;
    localparam logic [1:0] RESP_ERR    = 2'd2;
    localparam logic [1:0] RESP_INTERR = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OP2  = 2'd1,
        ST_EXEC = 2'd2,
        ST_RESP = 2'd3
    } state_t;

endpackage

// File: rtl/calc1_alu.sv
// rtl/calc1_alu.sv - combinational calc1 arithmetic: add, subtract, optional shifts
//   cmd    in   4   command code
//   op1    in   32  first operand
//   op2    in   32  second operand (shift amount = low 5 bits)
//   result out  32  result, 0 unless resp is RESP_OK
//   resp   out  2   RESP_OK or RESP_ERR
//   CALC1_SHIFT_EN: when defined, cmd 5/6 shift; otherwise they are invalid
module calc1_alu
    import calc1_pkg::*;
(
    input  logic [3:0]        cmd,
    input  logic [DATA_W-1:0] op1,
    input  logic [DATA_W-1:0] op2,
    output logic [DATA_W-1:0] result,
    output logic [1:0]        resp
);

    logic [DATA_W:0] sum;

    always_comb begin
        sum    = {1'b0, op1} + {1'b0, op2};
        result = '0;
        resp   = RESP_ERR;
        case (cmd)
            CMD_ADD: begin
                if (!sum[DATA_W]) begin
                    result = sum[DATA_W-1:0];
                    resp   = RESP_OK;
                end
            end
            CMD_SUB: begin
                if (op2 <= op1) begin
                    result = op1 - op2;
                    resp   = RESP_OK;
                end
            end
`ifdef CALC1_SHIFT_EN
            CMD_SHL: begin
                result = op1 << op2[4:0];
                resp   = RESP_OK;
            end
            CMD_SHR: begin
                result = op1 >> op2[4:0];
                resp   = RESP_OK;
            end
`endif
            default: begin
                result = '0;
                resp   = RESP_ERR;
            end
        endcase
    end

endmodule

// File: rtl/calc1_port_resp.sv
// rtl/calc1_port_resp.sv - calc1 request-port responder: cmd/op1, op2, fixed latency, one-cycle response
//   c_clk       in   1   clock, rising edge
//   reset       in   1   synchronous active-high reset
//   req_cmd_in  in   4   command (0 = no-op)
//   req_data_in in   32  op1 in command cycle, op2 in next cycle (bit 0 = MSB)
//   out_resp    out  2   response code, valid for one cycle
//   out_data    out  32  result when out_resp = 1, else 0 (bit 0 = MSB)
//   busy        out  1   high from op2 cycle through response cycle
//   LATENCY     param    cycles from op2 cycle to response cycle, 1..15
//   CALC1_SHIFT_EN: enables shift commands in calc1_alu
module calc1_port_resp
    import calc1_pkg::*;
#(
    parameter int LATENCY = 3
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic [3:0]  req_cmd_in,
    input  logic [0:31] req_data_in,
    output logic [1:0]  out_resp,
    output logic [0:31] out_data,
    output logic        busy
);

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_t state, state_n;
    logic [3:0]        cnt, cnt_n;
    logic [3:0]        cmd_q;
    logic [DATA_W-1:0] op1_q;
    logic [DATA_W-1:0] op2_q;
    logic [DATA_W-1:0] alu_op2;
    logic [DATA_W-1:0] alu_result;
    logic [1:0]        alu_resp;

    // With LATENCY = 1 the response is registered on the op2 edge itself,
    // before op2_q holds the operand, so take op2 straight from the bus.
    assign alu_op2 = (state == ST_OP2) ? DATA_W'(req_data_in) : op2_q;

    calc1_alu u_alu (
        .cmd    (cmd_q),
        .op1    (op1_q),
        .op2    (alu_op2),
        .result (alu_result),
        .resp   (alu_resp)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            ST_IDLE: begin
                if (req_cmd_in != CMD_NOP) begin
                    state_n = ST_OP2;
                end
            end
            ST_OP2: begin
                if (LATENCY == 1) begin
                    state_n = ST_RESP;
                end else begin
                    state_n = ST_EXEC;
                    cnt_n   = LAT_M1;
                end
            end
            ST_EXEC: begin
                // The response cycle follows the cycle whose decrement reaches 0.
                cnt_n = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    state_n = ST_RESP;
                end
            end
            ST_RESP: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge c_clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            cmd_q    <= CMD_NOP;
            op1_q    <= '0;
            op2_q    <= '0;
            out_resp <= RESP_NONE;
            out_data <= '0;
            busy     <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (state == ST_IDLE && req_cmd_in != CMD_NOP) begin
                cmd_q <= req_cmd_in;
                op1_q <= DATA_W'(req_data_in);
            end
            if (state == ST_OP2) begin
                op2_q <= DATA_W'(req_data_in);
            end
            if (state_n == ST_RESP) begin
                out_resp <= alu_resp;
                out_data <= (alu_resp == RESP_OK) ? alu_result : '0;
            end else begin
                out_resp <= RESP_NONE;
                out_data <= '0;
            end
            busy <= (state_n != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_calc1_port_resp.sv
// tb/tb_calc1_port_resp.sv - self-checking bench for calc1_port_resp
module tb_calc1_port_resp;

    localparam int LAT = 3;

    logic        c_clk = 1'b0;
    logic        reset;
    logic [3:0]  req_cmd_in;
    logic [0:31] req_data_in;
    logic [1:0]  out_resp;
    logic [0:31] out_data;
    logic        busy;

    int cyc = 0;
    int n_total = 0;
    int n_pass = 0;

    calc1_port_resp #(.LATENCY(LAT)) dut (
        .c_clk       (c_clk),
        .reset       (reset),
        .req_cmd_in  (req_cmd_in),
        .req_data_in (req_data_in),
        .out_resp    (out_resp),
        .out_data    (out_data),
        .busy        (busy)
    );

    always #5 c_clk = ~c_clk;
    always @(posedge c_clk) cyc++;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
        int          at;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [1:0]  resp;
        logic [31:0] data;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
    endtask

    // Scoreboard: pops on every response, flags unexpected and overdue ones.
    always @(negedge c_clk) begin
        if (!reset) begin
            if (out_resp != 2'd0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_resp", 32'(out_resp), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("resp", 32'(out_resp), 32'(e.resp));
                    chk("data", out_data, e.data);
                    chk("latency", 32'(cyc), 32'(e.at));
                end
            end else begin
                chk("idle_data", out_data, 32'd0);
                if (sb.size() > 0 && cyc > sb[0].at) begin
                    chk("missing_resp", 32'(cyc), 32'(sb[0].at));
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic drive(input logic [3:0] cmd, input logic [31:0] data);
        @(posedge c_clk);
        #1;
        req_cmd_in  = cmd;
        req_data_in = data;
    endtask

    task automatic push(input logic [1:0] resp, input logic [31:0] data, input int at);
        exp_t e;
        e.resp = resp;
        e.data = data;
        e.at   = at;
        sb.push_back(e);
    endtask

    task automatic do_txn(input logic [3:0] cmd, input logic [31:0] op1, input logic [31:0] op2,
                          input logic [1:0] resp, input logic [31:0] data);
        drive(cmd, op1);
        push(resp, data, cyc + LAT + 1);
        @(negedge c_clk);
        chk("busy_cmd_cycle", 32'(busy), 32'd0);
        drive(4'd0, op2);
        @(negedge c_clk);
        chk("busy_op2", 32'(busy), 32'd1);
        drive(4'd0, 32'd0);
        for (int i = 1; i <= LAT; i++) begin
            @(negedge c_clk);
            chk("busy_run", 32'(busy), 32'd1);
        end
        @(negedge c_clk);
        chk("busy_after", 32'(busy), 32'd0);
    endtask

    vec_t vecs[$];

    task automatic add_vec(input logic [3:0] cmd, input logic [31:0] op1, input logic [31:0] op2,
                           input logic [1:0] resp, input logic [31:0] data);
        vec_t v;
        v.cmd = cmd; v.op1 = op1; v.op2 = op2; v.resp = resp; v.data = data;
        vecs.push_back(v);
    endtask

    initial begin
        int n;
        add_vec(4'd1, 32'h0000_0001, 32'h01FF_FFFF, 2'd1, 32'h0200_0000);
        add_vec(4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 32'h0);
        add_vec(4'd2, 32'h0000_0001, 32'h0000_000F, 2'd2, 32'h0);
        add_vec(4'd2, 32'h0000_000F, 32'h0000_0001, 2'd1, 32'h0000_000E);
        add_vec(4'd3, 32'h0000_0005, 32'h0000_0001, 2'd2, 32'h0);
        add_vec(4'd4, 32'h0000_0005, 32'h0000_0001, 2'd2, 32'h0);
`ifdef CALC1_SHIFT_EN
        add_vec(4'd5, 32'h0000_0001, 32'hFFFF_FFE4, 2'd1, 32'h0000_0010);
        add_vec(4'd6, 32'h8000_0000, 32'd31,        2'd1, 32'h0000_0001);
        add_vec(4'd5, 32'hDEAD_BEEF, 32'hFFFF_FFE0, 2'd1, 32'hDEAD_BEEF);
`else
        add_vec(4'd5, 32'h0000_0001, 32'hFFFF_FFE4, 2'd2, 32'h0);
        add_vec(4'd6, 32'h8000_0000, 32'd31,        2'd2, 32'h0);
        add_vec(4'd5, 32'hDEAD_BEEF, 32'hFFFF_FFE0, 2'd2, 32'h0);
`endif
        add_vec(4'd1, 32'hFFFF_FFFF, 32'h0000_0000, 2'd1, 32'hFFFF_FFFF);
        add_vec(4'd1, 32'h7FFF_FFFF, 32'h8000_0000, 2'd1, 32'hFFFF_FFFF);
        add_vec(4'd2, 32'h0000_0005, 32'h0000_0005, 2'd1, 32'h0);
        add_vec(4'd2, 32'h0000_0000, 32'hFFFF_FFFF, 2'd2, 32'h0);
        add_vec(4'd1, 32'h0000_0000, 32'h0000_0000, 2'd1, 32'h0);
        add_vec(4'd15, 32'h0000_0007, 32'h0000_0007, 2'd2, 32'h0);

        reset       = 1'b1;
        req_cmd_in  = 4'd0;
        req_data_in = '0;
        repeat (4) @(posedge c_clk);
        #1;
        reset = 1'b0;
        @(negedge c_clk);
        chk("rst_resp", 32'(out_resp), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        foreach (vecs[i]) begin
            do_txn(vecs[i].cmd, vecs[i].op1, vecs[i].op2, vecs[i].resp, vecs[i].data);
        end

        // Commands in OP2, EXEC and RESP are ignored; the one after RESP is taken.
        drive(4'd1, 32'd2);
        n = cyc;
        push(2'd1, 32'd5, n + LAT + 1);
        drive(4'd2, 32'd3);
        drive(4'd1, 32'd7);
        drive(4'd1, 32'd8);
        drive(4'd1, 32'd9);
        @(negedge c_clk);
        chk("resp_cycle_seen", 32'(out_resp), 32'd1);
        drive(4'd2, 32'h0000_000F);
        push(2'd1, 32'h0000_000E, cyc + LAT + 1);
        drive(4'd0, 32'd1);
        drive(4'd0, 32'd0);
        repeat (LAT + 3) @(negedge c_clk);

        // Reset during EXEC aborts the transaction silently.
        drive(4'd1, 32'd5);
        drive(4'd0, 32'd6);
        drive(4'd0, 32'd0);
        reset = 1'b1;
        @(posedge c_clk);
        #1;
        reset = 1'b0;
        @(negedge c_clk);
        chk("abort_resp", 32'(out_resp), 32'd0);
        chk("abort_data", out_data, 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        repeat (LAT + 3) @(negedge c_clk);
        do_txn(4'd1, 32'd0, 32'd0, 2'd1, 32'd0);

        repeat (LAT + 4) @(negedge c_clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
